// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests an instruction word at PC, latches it into
// IR, and decodes the PC-control signals (jump / branch) for one cycle.
// Optional feature macro: FETCH_TIMEOUT_EN -- bounds the memory wait to 16
// REQ cycles, substituting a NOP and raising a sticky fetch_error.
// Handshake: mem_req is held high for every REQ cycle with mem_addr = PC; a
// read completes on the first rising edge in REQ where mem_ack=1, with
// mem_rdata sampled on that same edge. mem_ack is ignored in any other state.
module instruction_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] PC,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] reg_a_data,
    output logic [15:0] IR,
    output logic        instr_valid,
    output logic        pc_step,
    output logic        PL,
    output logic        JB,
    output logic        BC,
    output logic [15:0] jump_addr,
    output logic [15:0] branch_offset,
    output logic        fetch_error,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECODE = 2'd2
    } state_t;

    state_t state;

    // {PL, JB, BC} for a given opcode (IR[15:9]).
    function automatic logic [2:0] decode_ctrl(input logic [6:0] opcode);
        logic [2:0] ctrl;
        case (opcode)
            7'b1110000: ctrl = 3'b110;  // JMP
            7'b1100000: ctrl = 3'b100;  // BRZ
            7'b1100001: ctrl = 3'b101;  // BRN
            default:    ctrl = 3'b000;
        endcase
        return ctrl;
    endfunction

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt;
    logic       fetch_error_q;
    assign fetch_error = fetch_error_q;
`else
    assign fetch_error = 1'b0;
`endif

    assign mem_addr  = PC;
    assign jump_addr = reg_a_data;
    assign fsm_state = state;

    // Branch target: PC plus the sign-extended split 6-bit offset field.
    assign branch_offset = PC + {{10{IR[8]}}, IR[8:6], IR[2:0]};

    // Fetch FSM with all control outputs registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            IR          <= 16'h0000;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            pc_step     <= 1'b0;
            PL          <= 1'b0;
            JB          <= 1'b0;
            BC          <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt       <= 4'd0;
            fetch_error_q <= 1'b0;
`endif
        end else begin
            // One-cycle strobes default low; only the REQ->DECODE edge raises them.
            instr_valid <= 1'b0;
            pc_step     <= 1'b0;
            PL          <= 1'b0;
            JB          <= 1'b0;
            BC          <= 1'b0;
            mem_req     <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_REQ;
                    mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt <= 4'd0;
`endif
                end
                S_REQ: begin
                    if (mem_ack) begin
                        IR           <= mem_rdata;
                        state        <= S_DECODE;
                        instr_valid  <= 1'b1;
                        pc_step      <= 1'b1;
                        {PL, JB, BC} <= decode_ctrl(mem_rdata[15:9]);
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_cnt == 4'd15) begin
                        // 16th starved cycle: substitute a NOP and flag it.
                        IR            <= 16'h0000;
                        state         <= S_DECODE;
                        instr_valid   <= 1'b1;
                        pc_step       <= 1'b1;
                        fetch_error_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                        mem_req <= 1'b1;
`else
                    end else begin
                        mem_req <= 1'b1;
`endif
                    end
                end
                S_DECODE: begin
                    state   <= S_REQ;
                    mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt <= 4'd0;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: reactive memory responder that pushes every
// word it returns into exp_q, and a monitor that pops and checks on each
// instr_valid cycle. Honours FETCH_TIMEOUT_EN the same way as the design.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] PC;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] reg_a_data;
    logic [15:0] IR;
    logic        instr_valid;
    logic        pc_step;
    logic        PL, JB, BC;
    logic [15:0] jump_addr;
    logic [15:0] branch_offset;
    logic        fetch_error;
    logic [1:0]  fsm_state;

    instruction_fetch dut (
        .clock(clock), .reset(reset), .PC(PC),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_a_data(reg_a_data), .IR(IR),
        .instr_valid(instr_valid), .pc_step(pc_step),
        .PL(PL), .JB(JB), .BC(BC),
        .jump_addr(jump_addr), .branch_offset(branch_offset),
        .fetch_error(fetch_error), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_step   = 0;
    int n_req    = 0;
    int addr_bad = 0;
    logic exp_ferr = 1'b0;

    // responder controls (written by the stimulus process)
    logic        resp_en    = 1'b0;
    int          ack_delay  = 0;
    int          acks_left  = 0;
    logic [15:0] resp_word  = 16'h0000;
    int          wait_cnt   = 0;
    logic        rsp_ack    = 1'b0;
    logic [15:0] rsp_data   = 16'h0000;
    logic        man_ack    = 1'b0;
    logic [15:0] man_data   = 16'h0000;

    assign mem_ack   = resp_en ? rsp_ack  : man_ack;
    assign mem_rdata = resp_en ? rsp_data : man_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_ctrl(input logic [15:0] ir);
        case (ir[15:9])
            7'b1110000: return 3'b110;
            7'b1100000: return 3'b100;
            7'b1100001: return 3'b101;
            default:    return 3'b000;
        endcase
    endfunction

    // Monitor first, then memory responder, both on the falling edge.
    always @(negedge clock) begin
        logic [15:0] e;
        logic [15:0] tgt;
        if (reset) begin
            exp_q.delete();
            exp_ferr = 1'b0;
            wait_cnt = 0;
            rsp_ack  = 1'b0;
        end else begin
            if (mem_req) begin
                n_req++;
                if (mem_addr !== PC) addr_bad++;
            end
            if (pc_step) n_step++;
            if (instr_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(instr_valid), 32'd0);
                end else begin
                    e   = exp_q.pop_front();
                    tgt = PC + {{10{e[8]}}, e[8:6], e[2:0]};
                    check("ir", 32'(IR), 32'(e));
                    check("pl_jb_bc", 32'({PL, JB, BC}), 32'(exp_ctrl(e)));
                    check("pc_step", 32'(pc_step), 32'd1);
                    check("jump_addr", 32'(jump_addr), 32'(reg_a_data));
                    check("branch_offset", 32'(branch_offset), 32'(tgt));
                    check("fetch_error", 32'(fetch_error), 32'(exp_ferr));
                end
            end else begin
                check("ctrl_outside_decode", 32'({pc_step, PL, JB, BC}), 32'd0);
            end
            // memory responder
            rsp_ack = 1'b0;
            if (resp_en && mem_req) begin
                if (acks_left > 0 && wait_cnt >= ack_delay) begin
                    rsp_ack  = 1'b1;
                    rsp_data = resp_word;
                    exp_q.push_back(resp_word);
                    acks_left--;
                    wait_cnt = 0;
`ifdef FETCH_TIMEOUT_EN
                end else if (wait_cnt == 15) begin
                    exp_q.push_back(16'h0000);
                    exp_ferr = 1'b1;
                    wait_cnt = 0;
`endif
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        resp_en = 1'b0;
        man_ack = 1'b0;
        tick();
        tick();
    endtask

    // Reset, configure one fetch, release, and wait (bounded) for its DECODE.
    task automatic run_fetch(input logic [15:0] word, input int delay,
                             input logic [15:0] pc_v, input logic [15:0] ra,
                             input string tag);
        int v0, r0, s0, t;
        do_reset();
        PC = pc_v; reg_a_data = ra; resp_word = word;
        ack_delay = delay; acks_left = 1; resp_en = 1'b1;
        v0 = n_valid; r0 = n_req; s0 = n_step; addr_bad = 0;
        reset = 1'b0;
        t = 0;
        while (n_valid == v0 && t < 100) begin tick(); t++; end
        check({tag, "_done"}, 32'(n_valid - v0), 32'd1);
        check({tag, "_req_cycles"}, 32'(n_req - r0), 32'(delay + 1));
        check({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
        tick(); tick(); tick();
        check({tag, "_one_step"}, 32'(n_step - s0), 32'd1);
        check({tag, "_ir_hold"}, 32'(IR), 32'(word));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0, r0, t;
        reset = 1'b1; PC = 16'h0000; reg_a_data = 16'h0000;
        tick(); tick();

        // reset state
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_ir", 32'(IR), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ctrl", 32'({pc_step, PL, JB, BC}), 32'd0);
        check("rst_ferr", 32'(fetch_error), 32'd0);

        // basic fetch timing: IDLE(0), REQ(1), DECODE(2)
        do_reset();
        PC = 16'h0010; resp_word = 16'h0123; ack_delay = 0; acks_left = 1; resp_en = 1'b1;
        reset = 1'b0;
        #1 check("c0_mem_req", 32'(mem_req), 32'd0);
        tick();
        check("c1_mem_req", 32'(mem_req), 32'd1);
        check("c1_mem_addr", 32'(mem_addr), 32'h0010);
        check("c1_valid", 32'(instr_valid), 32'd0);
        tick();
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_step", 32'(pc_step), 32'd1);
        check("c2_ir", 32'(IR), 32'h0123);
        check("c2_pl", 32'(PL), 32'd0);
        tick();
        check("c3_back_to_req", 32'(mem_req), 32'd1);
        check("c3_valid_low", 32'(instr_valid), 32'd0);

        // decode patterns and branch arithmetic (monitor checks each DECODE)
        run_fetch(16'hE008, 0, 16'h0100, 16'h4000, "jmp");
        run_fetch(16'hC3C7, 0, 16'h0000, 16'h1111, "brn_wrap_down");
        run_fetch(16'hC001, 0, 16'hFFFF, 16'h2222, "brz_wrap_up");
        run_fetch(16'hE200, 0, 16'h1234, 16'h3333, "near_jmp");
        run_fetch(16'h1234, 2, 16'h0042, 16'h4444, "other");
        run_fetch(16'h5A5A, 4, 16'h0BEE, 16'h5555, "delay5");
        for (int i = 0; i < 4; i++)
            run_fetch(16'($urandom_range(0, 16'hFFFF)), $urandom_range(0, 6),
                      16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)), "rand");

        // reset mid-REQ with a coincident mem_ack
        do_reset();
        PC = 16'h0200;
        reset = 1'b0;
        tick();
        check("mid_req_up", 32'(mem_req), 32'd1);
        man_data = 16'hBEEF; man_ack = 1'b1;
        #1 reset = 1'b1;
        #1 check("mid_req_drop", 32'(mem_req), 32'd0);
        tick();
        check("mid_ir", 32'(IR), 32'd0);
        check("mid_state", 32'(fsm_state), 32'd0);
        check("mid_valid", 32'(instr_valid), 32'd0);
        man_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        // starved memory: NOP after 16 REQ cycles, sticky error
        do_reset();
        PC = 16'h0300; ack_delay = 1000; acks_left = 1; resp_word = 16'h7777; resp_en = 1'b1;
        v0 = n_valid; r0 = n_req;
        reset = 1'b0;
        t = 0;
        while (n_valid == v0 && t < 100) begin tick(); t++; end
        check("tmo_done", 32'(n_valid - v0), 32'd1);
        check("tmo_req_cycles", 32'(n_req - r0), 32'd16);
        check("tmo_ir", 32'(IR), 32'd0);
        check("tmo_ferr", 32'(fetch_error), 32'd1);
        ack_delay = 0; acks_left = 2; resp_word = 16'h0ABC;
        v0 = n_valid; t = 0;
        while (n_valid < v0 + 2 && t < 100) begin tick(); t++; end
        check("tmo_later_fetches", 32'(n_valid - v0), 32'd2);
        check("tmo_ferr_sticky", 32'(fetch_error), 32'd1);
        // ack on the 16th cycle wins over the timeout
        run_fetch(16'hA5A5, 15, 16'h0400, 16'h0000, "tmo_tie");
        check("tmo_tie_ferr", 32'(fetch_error), 32'd0);
`else
        // no timeout: REQ waits indefinitely
        do_reset();
        PC = 16'h0300; ack_delay = 1000; acks_left = 1; resp_en = 1'b1;
        v0 = n_valid; r0 = n_req;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("wait_no_valid", 32'(n_valid - v0), 32'd0);
        check("wait_req_cycles", 32'(n_req - r0), 32'd40);
        check("wait_mem_req", 32'(mem_req), 32'd1);
        check("wait_ferr", 32'(fetch_error), 32'd0);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
